// File: rtl/usb_line_pkg.sv
// Shared constants for the USB line-level codec: stuff run length default,
// J/K idle levels and the ones-counter width helper.
package usb_line_pkg;

  localparam int   STUFF_LEN_DEF = 6;
  localparam logic IDLE_J        = 1'b1;
  localparam logic IDLE_K        = 1'b0;
  localparam int   CNT_W         = $clog2(STUFF_LEN_DEF + 1);

  // Counter width able to hold 0..len inclusive.
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/nrzi_ones_cnt.sv
// Consecutive-ones counter used by both the TX stuffer and the RX destuffer.
// The caller decides when to increment; at_limit flags a stuff slot.
module nrzi_ones_cnt
  import usb_line_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF,
  parameter int CW        = cnt_w(STUFF_LEN)
) (
  input  logic          clk,
  input  logic          rst_L,
  input  logic          en,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          at_limit
);

  localparam logic [CW-1:0] LIMIT = CW'(STUFF_LEN);

  // Run length tracker; held at zero while stuffing is disabled.
  always_ff @(posedge clk) begin
    if (!rst_L || clr || !en) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = en && (count == LIMIT);

endmodule

// File: rtl/nrzi_stuff_codec.sv
// NRZI line codec with bit stuffing on TX and destuffing plus stuff-error
// detection on RX. One line bit per clock; both directions run independently.
module nrzi_stuff_codec
  import usb_line_pkg::*;
#(
  parameter int   STUFF_LEN  = STUFF_LEN_DEF,
  parameter bit   STUFF_EN   = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_J
) (
  input  logic clk,
  input  logic rst_L,
  input  logic tx_en,
  input  logic tx_bit,
  input  logic tx_valid,
  output logic tx_ready,
  output logic tx_out,
  input  logic rx_en,
  input  logic rx_in,
  output logic rx_bit,
  output logic rx_valid,
  output logic rx_stuff_err
);

  localparam int            CW    = cnt_w(STUFF_LEN);
  localparam logic [CW-1:0] LIMIT = CW'(STUFF_LEN);

  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] rx_cnt;
  logic          tx_at_lim;
  logic          rx_at_lim;
  logic          tx_stuff;
  logic          tx_take;
  logic          tx_clr;
  logic          tx_inc;
  logic          rx_last;
  logic          rx_d;
  logic          rx_slot_stuff;
  logic          rx_normal;
  logic          rx_clr;
  logic          rx_inc;

  // ---------------- TX: stuffing and NRZI encode ----------------
  assign tx_stuff = tx_en && tx_at_lim;
  // Nothing is accepted while in reset so an aborted packet owes no bits.
  assign tx_ready = rst_L && tx_en && !tx_stuff;
  assign tx_take  = tx_ready && tx_valid;
  assign tx_clr   = !tx_en || tx_stuff || (tx_take && !tx_bit);
  assign tx_inc   = tx_take && tx_bit && (tx_cnt != LIMIT);

  nrzi_ones_cnt #(.STUFF_LEN(STUFF_LEN), .CW(CW)) u_tx_cnt (
    .clk      (clk),
    .rst_L    (rst_L),
    .en       (STUFF_EN),
    .clr      (tx_clr),
    .inc      (tx_inc),
    .count    (tx_cnt),
    .at_limit (tx_at_lim)
  );

  // Line level: a 0 (data or stuffed) toggles, a 1 holds, idle forces J.
  always_ff @(posedge clk) begin
    if (!rst_L || !tx_en) begin
      tx_out <= IDLE_LEVEL;
    end else if (tx_stuff || (tx_take && !tx_bit)) begin
      tx_out <= ~tx_out;
    end
  end

  // ---------------- RX: NRZI decode and destuffing ----------------
  // Tracks the line even between packets so the first bit decodes against idle.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      rx_last <= IDLE_LEVEL;
    end else begin
      rx_last <= rx_in;
    end
  end

  assign rx_d          = (rx_in == rx_last);
  assign rx_slot_stuff = rx_en && rx_at_lim;
  assign rx_normal     = rx_en && !rx_at_lim;
  assign rx_clr        = !rx_en || rx_slot_stuff || !rx_d;
  assign rx_inc        = rx_normal && rx_d && (rx_cnt != LIMIT);

  nrzi_ones_cnt #(.STUFF_LEN(STUFF_LEN), .CW(CW)) u_rx_cnt (
    .clk      (clk),
    .rst_L    (rst_L),
    .en       (STUFF_EN),
    .clr      (rx_clr),
    .inc      (rx_inc),
    .count    (rx_cnt),
    .at_limit (rx_at_lim)
  );

  // Decoded bit strobe; a stuff slot is swallowed, and flagged if it was a 1.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      rx_bit       <= 1'b0;
      rx_valid     <= 1'b0;
      rx_stuff_err <= 1'b0;
    end else begin
      rx_valid     <= rx_normal;
      rx_stuff_err <= rx_slot_stuff && rx_d;
      if (rx_normal) begin
        rx_bit <= rx_d;
      end
    end
  end

endmodule

// File: tb/tb_nrzi_stuff_codec.sv
// Directed bench for nrzi_stuff_codec: a stuffing instance plus a no-stuff
// instance sharing the same stimulus.
module tb_nrzi_stuff_codec;

  logic clk = 1'b0;
  logic rst_L;
  logic tx_en, tx_bit, tx_valid, rx_en, rx_line, loop;
  logic rx_in;
  logic tx_ready, tx_out, rx_bit, rx_valid, rx_stuff_err;
  logic ns_tx_ready, ns_tx_out, ns_rx_bit, ns_rx_valid, ns_rx_stuff_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rx_in = loop ? tx_out : rx_line;

  nrzi_stuff_codec #(.STUFF_LEN(6), .STUFF_EN(1'b1), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst_L(rst_L), .tx_en(tx_en), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .rx_en(rx_en), .rx_in(rx_in),
    .rx_bit(rx_bit), .rx_valid(rx_valid), .rx_stuff_err(rx_stuff_err)
  );

  nrzi_stuff_codec #(.STUFF_LEN(6), .STUFF_EN(1'b0), .IDLE_LEVEL(1'b1)) dut_ns (
    .clk(clk), .rst_L(rst_L), .tx_en(tx_en), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .tx_ready(ns_tx_ready), .tx_out(ns_tx_out), .rx_en(rx_en), .rx_in(rx_in),
    .rx_bit(ns_rx_bit), .rx_valid(ns_rx_valid), .rx_stuff_err(ns_rx_stuff_err)
  );

  task automatic idle_cycle();
    @(negedge clk);
    tx_en = 1'b0; tx_valid = 1'b0; tx_bit = 1'b0; rx_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_L = 1'b0; loop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tx_en = 1'($urandom); tx_bit = 1'($urandom); tx_valid = 1'($urandom);
      rx_en = 1'($urandom); rx_line = 1'($urandom);
      #1;
      n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL rst_tx_ready: got %b want 0", tx_ready); end
      @(posedge clk); #1;
      n_cmp++; if (tx_out !== 1'b1) begin n_err++; $display("FAIL rst_tx_out: got %b want 1", tx_out); end
      n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
      n_cmp++; if (rx_stuff_err !== 1'b0) begin n_err++; $display("FAIL rst_rx_err: got %b want 0", rx_stuff_err); end
      n_cmp++; if (rx_bit !== 1'b0) begin n_err++; $display("FAIL rst_rx_bit: got %b want 0", rx_bit); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst_L = 1'b1; tx_en = 1'b0; rx_en = 1'b0; tx_valid = 1'b0; tx_bit = 1'b0; rx_line = 1'b1;
      #1;
      n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL post_rst_tx_ready: got %b want 0", tx_ready); end
      @(posedge clk); #1;
      n_cmp++; if (tx_out !== 1'b1) begin n_err++; $display("FAIL post_rst_tx_out: got %b want 1", tx_out); end
      n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_rx_valid: got %b want 0", rx_valid); end
      n_cmp++; if (rx_stuff_err !== 1'b0) begin n_err++; $display("FAIL post_rst_rx_err: got %b want 0", rx_stuff_err); end
    end
  endtask

  task automatic test_tx_encode();
    logic [3:0] bits = 4'b0010;   // sent LSB first: 0,1,0,0
    logic [3:0] exp  = 4'b0100;   // line LSB first: 0,0,1,0
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tx_en = 1'b1; tx_valid = 1'b1; tx_bit = bits[i];
      #1;
      n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL enc_ready[%0d]: got %b want 1", i, tx_ready); end
      @(posedge clk); #1;
      n_cmp++; if (tx_out !== exp[i]) begin n_err++; $display("FAIL enc_out[%0d]: got %b want %b", i, tx_out, exp[i]); end
    end
    idle_cycle();
    n_cmp++; if (tx_out !== 1'b1) begin n_err++; $display("FAIL enc_idle: got %b want 1", tx_out); end
  endtask

  task automatic test_tx_stuff();
    logic [8:0] exp_rdy = 9'b110111111;  // slot 0 at LSB; slot 6 is the stuff
    logic [8:0] exp_out = 9'b000111111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tx_en = 1'b1; tx_valid = 1'b1; tx_bit = 1'b1;
      #1;
      n_cmp++; if (tx_ready !== exp_rdy[i]) begin n_err++; $display("FAIL stuff_ready[%0d]: got %b want %b", i, tx_ready, exp_rdy[i]); end
      @(posedge clk); #1;
      n_cmp++; if (tx_out !== exp_out[i]) begin n_err++; $display("FAIL stuff_out[%0d]: got %b want %b", i, tx_out, exp_out[i]); end
    end
    idle_cycle();
  endtask

  task automatic test_rx_stuff_err();
    logic [7:0] exp_vld = 8'b10111111;
    logic [7:0] exp_err = 8'b01000000;
    loop = 1'b0;
    @(negedge clk); rx_en = 1'b0; rx_line = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_en = 1'b1; rx_line = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (rx_valid !== exp_vld[i]) begin n_err++; $display("FAIL rxerr_valid[%0d]: got %b want %b", i, rx_valid, exp_vld[i]); end
      n_cmp++; if (rx_stuff_err !== exp_err[i]) begin n_err++; $display("FAIL rxerr_err[%0d]: got %b want %b", i, rx_stuff_err, exp_err[i]); end
      if (exp_vld[i]) begin
        n_cmp++; if (rx_bit !== 1'b1) begin n_err++; $display("FAIL rxerr_bit[%0d]: got %b want 1", i, rx_bit); end
      end
      n_cmp++; if (ns_rx_stuff_err !== 1'b0 || ns_rx_valid !== 1'b1) begin
        n_err++; $display("FAIL nostuff_rx[%0d]: got valid=%b err=%b want valid=1 err=0", i, ns_rx_valid, ns_rx_stuff_err);
      end
    end
    idle_cycle();
  endtask

  task automatic test_loopback();
    logic pat[64];
    logic txq[$];
    logic rxq[$];
    int   k = 0;
    int   idx = 0;
    int   tail = 0;
    logic prev_en = 1'b0;
    logic err_seen = 1'b0;
    pat[k] = 1'b0; k++;
    for (int i = 0; i < 6; i++) begin pat[k] = 1'b1; k++; end
    pat[k] = 1'b0; k++;
    for (int i = 0; i < 7; i++) begin pat[k] = 1'b1; k++; end
    pat[k] = 1'b0; k++; pat[k] = 1'b0; k++;
    for (int i = 0; i < 12; i++) begin pat[k] = 1'b1; k++; end
    pat[k] = 1'b0; k++;
    while (k < 64) begin pat[k] = 1'($urandom); k++; end
    loop = 1'b1;
    for (int cyc = 0; cyc < 200 && tail < 3; cyc++) begin
      @(negedge clk);
      rx_en = prev_en;
      tx_en = (idx < 64);
      tx_valid = tx_en;
      tx_bit = (idx < 64) ? pat[idx] : 1'b0;
      #1;
      if (tx_ready && tx_valid) begin txq.push_back(tx_bit); idx++; end
      prev_en = tx_en;
      if (idx >= 64 && !tx_en) tail++;
      @(posedge clk); #1;
      if (rx_valid) rxq.push_back(rx_bit);
      if (rx_stuff_err) err_seen = 1'b1;
    end
    loop = 1'b0;
    idle_cycle();
    n_cmp++; if (idx != 64) begin n_err++; $display("FAIL loop_accepted: got %0d want 64", idx); end
    n_cmp++; if (rxq.size() != 64) begin n_err++; $display("FAIL loop_rx_count: got %0d want 64", rxq.size()); end
    for (int i = 0; i < 64; i++) begin
      if (i < rxq.size() && i < txq.size()) begin
        n_cmp++; if (rxq[i] !== pat[i]) begin n_err++; $display("FAIL loop_bit[%0d]: got %b want %b", i, rxq[i], pat[i]); end
      end
    end
    n_cmp++; if (err_seen !== 1'b0) begin n_err++; $display("FAIL loop_stuff_err: got %b want 0", err_seen); end
  endtask

  task automatic test_reset_midrun();
    logic [4:0] pre = 5'b11110;          // 0 then four 1s
    logic [6:0] exp_rdy = 7'b0111111;
    logic [6:0] exp_out = 7'b0111111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tx_en = 1'b1; tx_valid = 1'b1; tx_bit = pre[i];
      @(posedge clk); #1;
      n_cmp++; if (tx_out !== 1'b0) begin n_err++; $display("FAIL mid_pre_out[%0d]: got %b want 0", i, tx_out); end
    end
    @(negedge clk);
    rst_L = 1'b0; tx_bit = 1'b1;
    #1;
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", tx_ready); end
    @(posedge clk); #1;
    n_cmp++; if (tx_out !== 1'b1) begin n_err++; $display("FAIL mid_rst_out: got %b want 1", tx_out); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst_L = 1'b1; tx_en = 1'b1; tx_valid = 1'b1; tx_bit = 1'b1;
      #1;
      n_cmp++; if (tx_ready !== exp_rdy[i]) begin n_err++; $display("FAIL mid_ready[%0d]: got %b want %b", i, tx_ready, exp_rdy[i]); end
      @(posedge clk); #1;
      n_cmp++; if (tx_out !== exp_out[i]) begin n_err++; $display("FAIL mid_out[%0d]: got %b want %b", i, tx_out, exp_out[i]); end
    end
    idle_cycle();
  endtask

  task automatic test_nostuff();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tx_en = 1'b1; tx_valid = 1'b1; tx_bit = 1'b1;
      #1;
      n_cmp++; if (ns_tx_ready !== 1'b1) begin n_err++; $display("FAIL ns_ready[%0d]: got %b want 1", i, ns_tx_ready); end
      @(posedge clk); #1;
      n_cmp++; if (ns_tx_out !== 1'b1) begin n_err++; $display("FAIL ns_out[%0d]: got %b want 1", i, ns_tx_out); end
    end
    idle_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_L = 1'b0; tx_en = 1'b0; tx_bit = 1'b0; tx_valid = 1'b0;
    rx_en = 1'b0; rx_line = 1'b1; loop = 1'b0;
    test_reset();
    test_tx_encode();
    test_tx_stuff();
    test_rx_stuff_err();
    test_loopback();
    test_reset_midrun();
    test_nostuff();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
